// File: rtl/clk_mon.sv
// Presence and frequency monitor for a slow probe clock sampled as data in the clkin1 domain.
// Measures probe period and high time, qualifies against a tolerance window, reports lock/fault.
module clk_mon #(
  parameter int CNT_MAX  = 2500,
  parameter int TOL      = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 5000
) (
  input  logic        clkin1,
  input  logic        pll_rst,
  input  logic        clk_probe,
  output logic [15:0] period,
  output logic [15:0] high_time,
  output logic        period_vld,
  output logic        mon_lock,
  output logic        mon_fault
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MEAS   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]      LOCK_TGT  = GW'(LOCK_CNT);
  localparam logic [GW-1:0]      GOOD_ONE  = GW'(1);
  localparam logic [15:0]        TO_VAL    = 16'(TIMEOUT - 1);
  localparam logic signed [16:0] CNT_MAX_S = 17'(CNT_MAX);
  localparam logic signed [16:0] TOL_S     = 17'(TOL);

  logic        s1_reg, s2_reg, s3_reg;
  logic [15:0] cnt_reg;
  logic [15:0] hi_cnt_reg;
  logic [1:0]  state_reg, state_next;
  logic [GW-1:0] good_cnt_reg, good_cnt_next;
  logic        vld_next;
  logic [15:0] period_reg, high_time_reg;
  logic        period_vld_reg, mon_lock_reg, mon_fault_reg;

  logic               rise;
  logic               timeout;
  logic               good;
  logic [15:0]        meas;
  logic [15:0]        hi_cnt_inc;
  logic signed [16:0] diff;

  // Probe is asynchronous: two synchronizer stages plus one history stage for edge detection.
  always_ff @(posedge clkin1) begin
    if (pll_rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= clk_probe;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise       = s2_reg & ~s3_reg;
  assign meas       = (cnt_reg == 16'hFFFF) ? 16'hFFFF : cnt_reg + 16'd1;
  assign hi_cnt_inc = (hi_cnt_reg == 16'hFFFF) ? 16'hFFFF : hi_cnt_reg + {15'd0, s2_reg};
  assign diff       = $signed({1'b0, meas}) - CNT_MAX_S;
  assign good       = (diff <= TOL_S) && (diff >= -TOL_S);
  assign timeout    = ~rise && (cnt_reg == TO_VAL);

  always_ff @(posedge clkin1) begin
    if (pll_rst) begin
      cnt_reg    <= 16'd0;
      hi_cnt_reg <= 16'd0;
    end else if (rise) begin
      cnt_reg    <= 16'd0;
      hi_cnt_reg <= 16'd1;
    end else begin
      cnt_reg    <= (cnt_reg == 16'hFFFF) ? 16'hFFFF : cnt_reg + 16'd1;
      hi_cnt_reg <= hi_cnt_inc;
    end
  end

  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    vld_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // First edge only arms the monitor; there is no earlier edge to measure from.
        if (rise) begin
          state_next    = ST_MEAS;
          good_cnt_next = '0;
        end else if (timeout) begin
          state_next = ST_FAULT;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          vld_next = 1'b1;
          if (good) begin
            if (good_cnt_reg + GOOD_ONE == LOCK_TGT) begin
              state_next    = ST_LOCKED;
              good_cnt_next = LOCK_TGT;
            end else begin
              good_cnt_next = good_cnt_reg + GOOD_ONE;
            end
          end else begin
            good_cnt_next = '0;
          end
        end else if (timeout) begin
          state_next = ST_FAULT;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          vld_next = 1'b1;
          if (!good) begin
            state_next = ST_FAULT;
          end
        end else if (timeout) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (rise) begin
          vld_next = 1'b1;
          if (good) begin
            good_cnt_next = GOOD_ONE;
            state_next    = (LOCK_CNT == 1) ? ST_LOCKED : ST_MEAS;
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        good_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clkin1) begin
    if (pll_rst) begin
      state_reg      <= ST_IDLE;
      good_cnt_reg   <= '0;
      period_reg     <= 16'd0;
      high_time_reg  <= 16'd0;
      period_vld_reg <= 1'b0;
      mon_lock_reg   <= 1'b0;
      mon_fault_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      good_cnt_reg   <= good_cnt_next;
      period_vld_reg <= vld_next;
      mon_lock_reg   <= (state_next == ST_LOCKED);
      mon_fault_reg  <= (state_next == ST_FAULT);
      if (vld_next) begin
        period_reg    <= meas;
        high_time_reg <= hi_cnt_reg;
      end
    end
  end

  assign period     = period_reg;
  assign high_time  = high_time_reg;
  assign period_vld = period_vld_reg;
  assign mon_lock   = mon_lock_reg;
  assign mon_fault  = mon_fault_reg;

endmodule

// File: tb/tb_clk_mon.sv
// Bench for clk_mon: table of probe pulses with expected measurements, checked through a
// scoreboard, plus hand-written timeout and reset sequences.
module tb_clk_mon;

  localparam int CNT_MAX  = 2500;
  localparam int TOL      = 16;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 5000;

  logic        clkin1 = 1'b0;
  logic        pll_rst = 1'b1;
  logic        clk_probe = 1'b0;
  logic [15:0] period, high_time;
  logic        period_vld, mon_lock, mon_fault;

  clk_mon #(
    .CNT_MAX (CNT_MAX),
    .TOL     (TOL),
    .LOCK_CNT(LOCK_CNT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clkin1    (clkin1),
    .pll_rst   (pll_rst),
    .clk_probe (clk_probe),
    .period    (period),
    .high_time (high_time),
    .period_vld(period_vld),
    .mon_lock  (mon_lock),
    .mon_fault (mon_fault)
  );

  always #5 clkin1 = ~clkin1;

  int cyc = 0;
  always @(posedge clkin1) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int p;
    int h;
    bit l;
    bit f;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
    bit vld;
    int ep;
    int eh;
    bit el;
    bit ef;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  exp_t mon_e;
  always @(negedge clkin1) begin
    if (period_vld) begin
      $display("vld @%0d period=%0d high=%0d lock=%0b fault=%0b",
               cyc, period, high_time, mon_lock, mon_fault);
      if (sb.size() == 0) begin
        chk("unexpected_vld", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("vld_cycle", cyc, mon_e.cyc);
        chk("period", int'(period), mon_e.p);
        chk("high_time", int'(high_time), mon_e.h);
        chk("mon_lock", int'(mon_lock), int'(mon_e.l));
        chk("mon_fault", int'(mon_fault), int'(mon_e.f));
      end
    end
  end

  task automatic push_exp(input int ep, input int eh, input bit el, input bit ef);
    exp_t e;
    e.cyc = cyc + 3;
    e.p   = ep;
    e.h   = eh;
    e.l   = el;
    e.f   = ef;
    sb.push_back(e);
  endtask

  // Called on a negedge; drives one probe pulse of hi+lo cycles starting with a rising edge.
  task automatic send_edge(input vec_t v);
    clk_probe = 1'b1;
    if (v.vld) push_exp(v.ep, v.eh, v.el, v.ef);
    repeat (v.hi) @(negedge clkin1);
    clk_probe = 1'b0;
    repeat (v.lo) @(negedge clkin1);
  endtask

  task automatic do_reset(output int rel);
    pll_rst = 1'b1;
    @(negedge clkin1);
    chk("rst_period", int'(period), 0);
    chk("rst_high_time", int'(high_time), 0);
    chk("rst_period_vld", int'(period_vld), 0);
    chk("rst_mon_lock", int'(mon_lock), 0);
    chk("rst_mon_fault", int'(mon_fault), 0);
    pll_rst = 1'b0;
    rel = cyc;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clkin1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected completion before cycle 90000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;
    int c;
    // Lock from reset at nominal 2500/1250.
    tbl[0]  = '{1250, 1250, 1'b0,    0,    0, 1'b0, 1'b0};
    tbl[1]  = '{1250, 1250, 1'b1, 2500, 1250, 1'b0, 1'b0};
    tbl[2]  = '{1250, 1250, 1'b1, 2500, 1250, 1'b0, 1'b0};
    tbl[3]  = '{1250, 1250, 1'b1, 2500, 1250, 1'b0, 1'b0};
    tbl[4]  = '{1250, 1250, 1'b1, 2500, 1250, 1'b1, 1'b0};
    // After a mid-period reset: arm, tolerance edges 2516/2517/2484, 2400 fault, relock.
    tbl[5]  = '{1250, 1250, 1'b0,    0,    0, 1'b0, 1'b0};
    tbl[6]  = '{1258, 1258, 1'b1, 2500, 1250, 1'b0, 1'b0};
    tbl[7]  = '{1258, 1259, 1'b1, 2516, 1258, 1'b0, 1'b0};
    tbl[8]  = '{1242, 1242, 1'b1, 2517, 1258, 1'b0, 1'b0};
    tbl[9]  = '{1258, 1258, 1'b1, 2484, 1242, 1'b0, 1'b0};
    tbl[10] = '{1242, 1242, 1'b1, 2516, 1258, 1'b0, 1'b0};
    tbl[11] = '{1250, 1250, 1'b1, 2484, 1242, 1'b0, 1'b0};
    tbl[12] = '{1200, 1200, 1'b1, 2500, 1250, 1'b1, 1'b0};
    tbl[13] = '{1250, 1250, 1'b1, 2400, 1200, 1'b0, 1'b1};
    tbl[14] = '{1250, 1250, 1'b1, 2500, 1250, 1'b0, 1'b0};
    tbl[15] = '{1250, 1250, 1'b1, 2500, 1250, 1'b0, 1'b0};
    tbl[16] = '{1250, 1250, 1'b1, 2500, 1250, 1'b0, 1'b0};
    tbl[17] = '{1250, 1250, 1'b1, 2500, 1250, 1'b1, 1'b0};

    @(negedge clkin1);
    do_reset(rel);
    repeat (3) @(negedge clkin1);
    for (int i = 0; i < 5; i++) send_edge(tbl[i]);

    // Sixth edge measured while locked, then reset during the low phase.
    c = cyc;
    clk_probe = 1'b1;
    push_exp(2500, 1250, 1'b1, 1'b0);
    repeat (1250) @(negedge clkin1);
    clk_probe = 1'b0;
    wait_until(c + 1800);
    do_reset(rel);
    wait_until(c + 2500);

    for (int i = 5; i < 18; i++) send_edge(tbl[i]);

    // Locked, then probe held low past the timeout.
    c = cyc;
    clk_probe = 1'b1;
    push_exp(2500, 1250, 1'b1, 1'b0);
    repeat (1250) @(negedge clkin1);
    clk_probe = 1'b0;
    wait_until(c + 3 + TIMEOUT - 1);
    chk("to_fault_before", int'(mon_fault), 0);
    chk("to_lock_before", int'(mon_lock), 1);
    @(negedge clkin1);
    chk("to_fault_at", int'(mon_fault), 1);
    chk("to_lock_at", int'(mon_lock), 0);
    wait_until(c + 6000);
    clk_probe = 1'b1;
    push_exp(6000, 1250, 1'b0, 1'b1);
    repeat (20) @(negedge clkin1);
    clk_probe = 1'b0;
    repeat (20) @(negedge clkin1);

    // Probe held low from reset.
    do_reset(rel);
    wait_until(rel + TIMEOUT - 1);
    chk("idle_low_fault_before", int'(mon_fault), 0);
    @(negedge clkin1);
    chk("idle_low_fault_at", int'(mon_fault), 1);
    chk("idle_low_lock", int'(mon_lock), 0);

    // Probe held high from reset: the synchronizer sees one rise that only arms.
    clk_probe = 1'b1;
    do_reset(rel);
    wait_until(rel + TIMEOUT + 2);
    chk("idle_high_fault_before", int'(mon_fault), 0);
    @(negedge clkin1);
    chk("idle_high_fault_at", int'(mon_fault), 1);
    chk("idle_high_lock", int'(mon_lock), 0);
    clk_probe = 1'b0;
    repeat (10) @(negedge clkin1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
